// File: rtl/text_writer.sv
// text_writer: turns a character byte stream into text-buffer RAM writes.
// A cursor tracks the next cell. Printable bytes are written and advance the
// cursor. LF, CR, BS and FF move the cursor or clear rows/the whole screen.
// Ports:
//   i_pix_clk, i_rst_n        - clock, async active-low reset
//   i_char, i_char_valid      - input byte and its valid strobe
//   o_ready                   - byte accepted this cycle when valid (combinational)
//   o_wr_en/addr/data         - registered one-cycle text buffer write, addr = {row, col}
//   o_cursor_col/row          - current cursor position
module text_writer #(
    parameter int unsigned COLS = 32,
    parameter int unsigned ROWS = 16,
    localparam int unsigned COL_W = $clog2(COLS),
    localparam int unsigned ROW_W = $clog2(ROWS),
    localparam int unsigned AW    = ROW_W + COL_W
) (
    input  logic             i_pix_clk,
    input  logic             i_rst_n,
    input  logic [7:0]       i_char,
    input  logic             i_char_valid,
    output logic             o_ready,
    output logic             o_wr_en,
    output logic [AW-1:0]    o_wr_addr,
    output logic [7:0]       o_wr_data,
    output logic [COL_W-1:0] o_cursor_col,
    output logic [ROW_W-1:0] o_cursor_row
);

    typedef enum logic [1:0] {
        IDLE,
        CLEAR_ROW,
        CLEAR_ALL
    } state_e;

    localparam logic [7:0] CH_SPACE = 8'h20;

    state_e           state_q, state_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [AW-1:0]    cnt_q, cnt_d;
    // Set once the last clear write has been issued; the following cycle returns to IDLE.
    logic             done_q, done_d;
    logic             wr_en_q, wr_en_d;
    logic [AW-1:0]    wr_addr_q, wr_addr_d;
    logic [7:0]       wr_data_q, wr_data_d;
    logic [COL_W-1:0] col_dec;

    assign col_dec = col_q - COL_W'(1);

    // State register.
    always_ff @(posedge i_pix_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            col_q     <= '0;
            row_q     <= '0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            row_q     <= row_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    // Next-state, cursor and write decode.
    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        row_d     = row_q;
        cnt_d     = cnt_q;
        done_d    = done_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;

        case (state_q)
            IDLE: begin
                if (i_char_valid) begin
                    if (i_char >= CH_SPACE) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = {row_q, col_q};
                        wr_data_d = i_char;
                        if (col_q == COL_W'(COLS - 1)) begin
                            col_d   = '0;
                            row_d   = row_q + ROW_W'(1);
                            cnt_d   = '0;
                            done_d  = 1'b0;
                            state_d = CLEAR_ROW;
                        end else begin
                            col_d = col_q + COL_W'(1);
                        end
                    end else begin
                        case (i_char)
                            8'h0A: begin
                                col_d   = '0;
                                row_d   = row_q + ROW_W'(1);
                                cnt_d   = '0;
                                done_d  = 1'b0;
                                state_d = CLEAR_ROW;
                            end
                            8'h0D: col_d = '0;
                            8'h08: begin
                                // Backspace stops at column 0; never moves up a row.
                                if (col_q != '0) begin
                                    col_d     = col_dec;
                                    wr_en_d   = 1'b1;
                                    wr_addr_d = {row_q, col_dec};
                                    wr_data_d = CH_SPACE;
                                end
                            end
                            8'h0C: begin
                                col_d   = '0;
                                row_d   = '0;
                                cnt_d   = '0;
                                done_d  = 1'b0;
                                state_d = CLEAR_ALL;
                            end
                            default: ;
                        endcase
                    end
                end
            end

            CLEAR_ROW: begin
                if (done_q) begin
                    done_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = {row_q, cnt_q[COL_W-1:0]};
                    wr_data_d = CH_SPACE;
                    if (cnt_q == AW'(COLS - 1)) done_d = 1'b1;
                    else                        cnt_d  = cnt_q + AW'(1);
                end
            end

            CLEAR_ALL: begin
                if (done_q) begin
                    done_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = cnt_q;
                    wr_data_d = CH_SPACE;
                    if (cnt_q == AW'(COLS * ROWS - 1)) done_d = 1'b1;
                    else                               cnt_d  = cnt_q + AW'(1);
                end
            end

            default: state_d = IDLE;
        endcase
    end

    assign o_ready      = (state_q == IDLE);
    assign o_wr_en      = wr_en_q;
    assign o_wr_addr    = wr_addr_q;
    assign o_wr_data    = wr_data_q;
    assign o_cursor_col = col_q;
    assign o_cursor_row = row_q;

endmodule

// File: tb/tb_text_writer.sv
// Directed bench for text_writer: inputs driven and outputs sampled on the falling edge.
module tb_text_writer;

    logic       i_pix_clk;
    logic       i_rst_n;
    logic [7:0] i_char;
    logic       i_char_valid;
    logic       o_ready;
    logic       o_wr_en;
    logic [8:0] o_wr_addr;
    logic [7:0] o_wr_data;
    logic [4:0] o_cursor_col;
    logic [3:0] o_cursor_row;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    text_writer #(.COLS(32), .ROWS(16)) dut (
        .i_pix_clk    (i_pix_clk),
        .i_rst_n      (i_rst_n),
        .i_char       (i_char),
        .i_char_valid (i_char_valid),
        .o_ready      (o_ready),
        .o_wr_en      (o_wr_en),
        .o_wr_addr    (o_wr_addr),
        .o_wr_data    (o_wr_data),
        .o_cursor_col (o_cursor_col),
        .o_cursor_row (o_cursor_row)
    );

    initial i_pix_clk = 1'b0;
    always #5 i_pix_clk = ~i_pix_clk;

    // Wait (bounded) for a falling edge with o_ready high.
    task automatic wait_ready();
        int n = 0;
        @(negedge i_pix_clk);
        while (!o_ready && n < 2000) begin
            @(negedge i_pix_clk);
            n++;
        end
        if (!o_ready) begin
            chk_cnt++;
            $display("FAIL ready_timeout: o_ready=%0b required 1", o_ready);
        end
    endtask

    // Present one byte; it is accepted on the next rising edge.
    task automatic send(input logic [7:0] b);
        wait_ready();
        i_char       = b;
        i_char_valid = 1'b1;
        @(posedge i_pix_clk);
        #1;
        i_char_valid = 1'b0;
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0; i_char_valid = 1'b0; i_char = 8'h00;
        repeat (3) @(negedge i_pix_clk);
        chk_cnt++;
        if ({o_wr_en, o_wr_addr, o_wr_data, o_cursor_col, o_cursor_row} !== 27'd0)
            $display("FAIL reset_outputs: wr_en=%0b addr=%h data=%h col=%0d row=%0d required all 0",
                     o_wr_en, o_wr_addr, o_wr_data, o_cursor_col, o_cursor_row);
        else pass_cnt++;
        i_rst_n = 1'b1;
        @(negedge i_pix_clk);
        chk_cnt++;
        if (o_ready !== 1'b1) $display("FAIL reset_ready: o_ready=%0b required 1", o_ready);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        @(negedge i_pix_clk);
        i_char = 8'h41; i_char_valid = 1'b1;
        @(negedge i_pix_clk);
        chk_cnt++;
        if (o_wr_en !== 1'b1 || o_wr_addr !== 9'h000 || o_wr_data !== 8'h41 || o_ready !== 1'b1)
            $display("FAIL ab_first: en=%0b addr=%h data=%h rdy=%0b required 1/000/41/1",
                     o_wr_en, o_wr_addr, o_wr_data, o_ready);
        else pass_cnt++;
        i_char = 8'h42;
        @(negedge i_pix_clk);
        i_char_valid = 1'b0;
        chk_cnt++;
        if (o_wr_en !== 1'b1 || o_wr_addr !== 9'h001 || o_wr_data !== 8'h42 || o_ready !== 1'b1)
            $display("FAIL ab_second: en=%0b addr=%h data=%h rdy=%0b required 1/001/42/1",
                     o_wr_en, o_wr_addr, o_wr_data, o_ready);
        else pass_cnt++;
        chk_cnt++;
        if (o_cursor_col !== 5'd2 || o_cursor_row !== 4'd0)
            $display("FAIL ab_cursor: col=%0d row=%0d required 2/0", o_cursor_col, o_cursor_row);
        else pass_cnt++;
    endtask

    task automatic test_col_wrap();
        for (int i = 0; i < 29; i++) send(8'h61);
        @(negedge i_pix_clk);
        chk_cnt++;
        if (o_cursor_col !== 5'd31 || o_cursor_row !== 4'd0)
            $display("FAIL pre_wrap_cursor: col=%0d row=%0d required 31/0", o_cursor_col, o_cursor_row);
        else pass_cnt++;
        send(8'h5A);
        @(negedge i_pix_clk);
        chk_cnt++;
        if (o_wr_en !== 1'b1 || o_wr_addr !== 9'h01F || o_wr_data !== 8'h5A || o_ready !== 1'b0)
            $display("FAIL wrap_char: en=%0b addr=%h data=%h rdy=%0b required 1/01f/5a/0",
                     o_wr_en, o_wr_addr, o_wr_data, o_ready);
        else pass_cnt++;
        chk_cnt++;
        if (o_cursor_col !== 5'd0 || o_cursor_row !== 4'd1)
            $display("FAIL wrap_cursor: col=%0d row=%0d required 0/1", o_cursor_col, o_cursor_row);
        else pass_cnt++;
        for (int k = 0; k < 32; k++) begin
            @(negedge i_pix_clk);
            chk_cnt++;
            if (o_wr_en !== 1'b1 || o_wr_addr !== 9'(32 + k) || o_wr_data !== 8'h20 || o_ready !== 1'b0)
                $display("FAIL wrap_clear k=%0d: en=%0b addr=%h data=%h rdy=%0b required 1/%h/20/0",
                         k, o_wr_en, o_wr_addr, o_wr_data, o_ready, 9'(32 + k));
            else pass_cnt++;
        end
        @(negedge i_pix_clk);
        chk_cnt++;
        if (o_ready !== 1'b1 || o_wr_en !== 1'b0)
            $display("FAIL wrap_done: rdy=%0b en=%0b required 1/0", o_ready, o_wr_en);
        else pass_cnt++;
    endtask

    task automatic test_row_wrap();
        for (int i = 0; i < 14; i++) send(8'h0A);
        for (int i = 0; i < 3; i++) send(8'h62);
        wait_ready();
        chk_cnt++;
        if (o_cursor_col !== 5'd3 || o_cursor_row !== 4'd15)
            $display("FAIL pre_lf_cursor: col=%0d row=%0d required 3/15", o_cursor_col, o_cursor_row);
        else pass_cnt++;
        send(8'h0A);
        @(negedge i_pix_clk);
        chk_cnt++;
        if (o_wr_en !== 1'b0 || o_ready !== 1'b0)
            $display("FAIL lf_no_char: en=%0b rdy=%0b required 0/0", o_wr_en, o_ready);
        else pass_cnt++;
        for (int k = 0; k < 32; k++) begin
            @(negedge i_pix_clk);
            chk_cnt++;
            if (o_wr_en !== 1'b1 || o_wr_addr !== 9'(k) || o_wr_data !== 8'h20)
                $display("FAIL lf_clear k=%0d: en=%0b addr=%h data=%h required 1/%h/20",
                         k, o_wr_en, o_wr_addr, o_wr_data, 9'(k));
            else pass_cnt++;
        end
        @(negedge i_pix_clk);
        chk_cnt++;
        if (o_ready !== 1'b1 || o_cursor_col !== 5'd0 || o_cursor_row !== 4'd0)
            $display("FAIL lf_done: rdy=%0b col=%0d row=%0d required 1/0/0", o_ready, o_cursor_col, o_cursor_row);
        else pass_cnt++;
    endtask

    task automatic test_backspace();
        send(8'h0A);
        send(8'h0A);
        for (int i = 0; i < 5; i++) send(8'h63);
        send(8'h08);
        @(negedge i_pix_clk);
        chk_cnt++;
        if (o_wr_en !== 1'b1 || o_wr_addr !== 9'h044 || o_wr_data !== 8'h20 || o_cursor_col !== 5'd4)
            $display("FAIL bs_write: en=%0b addr=%h data=%h col=%0d required 1/044/20/4",
                     o_wr_en, o_wr_addr, o_wr_data, o_cursor_col);
        else pass_cnt++;
        send(8'h0D);
        @(negedge i_pix_clk);
        chk_cnt++;
        if (o_wr_en !== 1'b0 || o_cursor_col !== 5'd0 || o_cursor_row !== 4'd2)
            $display("FAIL cr: en=%0b col=%0d row=%0d required 0/0/2", o_wr_en, o_cursor_col, o_cursor_row);
        else pass_cnt++;
        send(8'h08);
        @(negedge i_pix_clk);
        chk_cnt++;
        if (o_wr_en !== 1'b0 || o_cursor_col !== 5'd0 || o_cursor_row !== 4'd2)
            $display("FAIL bs_col0: en=%0b col=%0d row=%0d required 0/0/2", o_wr_en, o_cursor_col, o_cursor_row);
        else pass_cnt++;
        send(8'h01);
        @(negedge i_pix_clk);
        chk_cnt++;
        if (o_wr_en !== 1'b0 || o_ready !== 1'b1 || o_cursor_col !== 5'd0)
            $display("FAIL ctrl_ignored: en=%0b rdy=%0b col=%0d required 0/1/0", o_wr_en, o_ready, o_cursor_col);
        else pass_cnt++;
    endtask

    task automatic test_clear_all();
        send(8'h0C);
        // Keep a byte pending through the clear; it must not be consumed early.
        i_char = 8'h58; i_char_valid = 1'b1;
        @(negedge i_pix_clk);
        chk_cnt++;
        if (o_wr_en !== 1'b0 || o_ready !== 1'b0 || o_cursor_col !== 5'd0 || o_cursor_row !== 4'd0)
            $display("FAIL ff_entry: en=%0b rdy=%0b col=%0d row=%0d required 0/0/0/0",
                     o_wr_en, o_ready, o_cursor_col, o_cursor_row);
        else pass_cnt++;
        for (int k = 0; k < 512; k++) begin
            @(negedge i_pix_clk);
            chk_cnt++;
            if (o_wr_en !== 1'b1 || o_wr_addr !== 9'(k) || o_wr_data !== 8'h20 || o_ready !== 1'b0)
                $display("FAIL ff_clear k=%0d: en=%0b addr=%h data=%h rdy=%0b required 1/%h/20/0",
                         k, o_wr_en, o_wr_addr, o_wr_data, o_ready, 9'(k));
            else pass_cnt++;
        end
        @(negedge i_pix_clk);
        i_char_valid = 1'b0;
        chk_cnt++;
        if (o_ready !== 1'b1 || o_wr_en !== 1'b0 || o_cursor_col !== 5'd0 || o_cursor_row !== 4'd0)
            $display("FAIL ff_done: rdy=%0b en=%0b col=%0d row=%0d required 1/0/0/0",
                     o_ready, o_wr_en, o_cursor_col, o_cursor_row);
        else pass_cnt++;
        @(negedge i_pix_clk);
        chk_cnt++;
        if (o_wr_en !== 1'b0 || o_cursor_col !== 5'd0)
            $display("FAIL ff_hold: en=%0b col=%0d required 0/0", o_wr_en, o_cursor_col);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_clear();
        send(8'h41);
        send(8'h0C);
        repeat (101) @(negedge i_pix_clk);
        chk_cnt++;
        if (o_wr_en !== 1'b1 || o_wr_addr !== 9'd99)
            $display("FAIL pre_abort: en=%0b addr=%h required 1/063", o_wr_en, o_wr_addr);
        else pass_cnt++;
        @(negedge i_pix_clk);
        i_rst_n = 1'b0;
        #1;
        chk_cnt++;
        if (o_wr_en !== 1'b0 || o_cursor_col !== 5'd0 || o_cursor_row !== 4'd0 || o_ready !== 1'b1)
            $display("FAIL abort: en=%0b col=%0d row=%0d rdy=%0b required 0/0/0/1",
                     o_wr_en, o_cursor_col, o_cursor_row, o_ready);
        else pass_cnt++;
        @(negedge i_pix_clk);
        i_rst_n = 1'b1;
        send(8'h51);
        @(negedge i_pix_clk);
        chk_cnt++;
        if (o_wr_en !== 1'b1 || o_wr_addr !== 9'h000 || o_wr_data !== 8'h51 || o_cursor_col !== 5'd1)
            $display("FAIL post_reset_q: en=%0b addr=%h data=%h col=%0d required 1/000/51/1",
                     o_wr_en, o_wr_addr, o_wr_data, o_cursor_col);
        else pass_cnt++;
    endtask

    initial begin
        i_rst_n = 1'b0; i_char_valid = 1'b0; i_char = 8'h00;
        test_reset();
        test_back_to_back();
        test_col_wrap();
        test_row_wrap();
        test_backspace();
        test_clear_all();
        test_reset_mid_clear();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/text_writer.md
# text_writer

Writes a byte stream into the text-buffer RAM that the tile layer reads: it turns a character stream from a UART receiver or CPU into text-buffer writes. A cursor tracks the next cell to write. Control bytes move the cursor and clear rows or the whole screen. The RAM write port runs on the pixel clock, so the buffer and this block share one clock domain with the display path.

## Interface
- COLS, 32, columns per text row; must be a power of two.
- ROWS, 16, text rows; must be a power of two.
- COL_W, log2(COLS)=5, column index width (derived).
- ROW_W, log2(ROWS)=4, row index width (derived).
- i_pix_clk  in  1  the only clock; all state changes on its rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_char  in  8  input byte.
- i_char_valid  in  1  i_char is valid this cycle.
- o_ready  out  1  block accepts a byte this cycle.
- o_wr_en  out  1  one-cycle write strobe to the text buffer.
- o_wr_addr  out  ROW_W+COL_W  write address, equal to {row, col}.
- o_wr_data  out  8  byte to write.
- o_cursor_col  out  COL_W  current cursor column.
- o_cursor_row  out  ROW_W  current cursor row.

## Operation
- Handshake is valid/ready. A byte is accepted on any rising edge where i_char_valid && o_ready. The source holds i_char while o_ready=0.
- o_ready = (state==IDLE), decoded combinationally from the state register.
- States and transitions:
  - IDLE -> CLEAR_ROW on a row advance.
  - IDLE -> CLEAR_ALL on byte 0x0C.
  - CLEAR_ROW -> IDLE after COLS clear writes.
  - CLEAR_ALL -> IDLE after COLS*ROWS clear writes.
- Byte handling in IDLE, at the accept edge:
  - 0x20..0xFF (printable): write i_char at {row,col}, then advance col.
  - If col was COLS-1, printable bytes also set col=0 and row=(row+1) mod ROWS. This is a row advance.
  - 0x0A (LF): col=0, row=(row+1) mod ROWS. This is a row advance; no character write.
  - 0x0D (CR): col=0; no write.
  - 0x08 (BS): if col>0, col=col-1 and write 0x20 at the new position. If col==0, no change and no write; BS never moves to the previous row.
  - 0x0C (FF): enter CLEAR_ALL.
  - Any other byte 0x00..0x1F: accepted and ignored.
- CLEAR_ROW clears the newly entered row: writes 0x20 to {new_row, k} for k=0..COLS-1, in ascending order. The cursor stays at {new_row, 0}.
- CLEAR_ALL writes 0x20 to addresses 0..COLS*ROWS-1 in ascending order, with the cursor forced to 0,0 on entry.
- Row wrap at the bottom goes to row 0 and clears it. There is no scrolling.
- Exactly one write per cycle at most; the block never reads the buffer.

## Timing
- Reset values: o_wr_en=0, o_wr_addr=0, o_wr_data=0, cursor 0/0, state IDLE. o_ready=1 from the first cycle after reset release.
- All write outputs are registered. A byte accepted at edge N produces its write during cycle N+1 (o_wr_en high for exactly that cycle).
- Row advance accepted at edge N:
  - The char write, if any, occurs in cycle N+1.
  - Clear writes occur in cycles N+2..N+COLS+1.
  - o_ready is low in cycles N+1..N+COLS+1 and high in cycle N+COLS+2.
- FF accepted at edge N: clear writes occur in cycles N+2..N+COLS*ROWS+1, and o_ready is high again in cycle N+COLS*ROWS+2.
- Cursor outputs update at the accept edge and are valid from cycle N+1.
- Back-to-back printable bytes: one byte per cycle is sustained, with no bubble unless a row advance occurs.
- i_char_valid while o_ready=0: no effect and no state change.
- Reset asserted mid-clear: the clear aborts immediately. o_wr_en drops asynchronously and the cursor returns to 0/0. The buffer holds partial contents; no recovery is required.
- Arithmetic: col and row increments wrap modulo COLS and ROWS respectively. The clear counter is ROW_W+COL_W bits wide and stops at its terminal count.

## Test plan
- After reset, send "AB" on consecutive cycles:
  - Writes appear at 0x000 with data 0x41, then 0x001 with data 0x42, in consecutive cycles.
  - Cursor ends at col 2, row 0, and o_ready stays 1 throughout.
- At col 31, row 0, send 'Z':
  - Write at 0x01F with data 0x5A.
  - Then 32 writes of 0x20 at 0x020..0x03F.
  - o_ready low for 33 cycles; cursor ends at col 0, row 1.
- At row 15, col 3, send 0x0A: 32 clear writes at 0x000..0x01F, cursor ends at 0/0, and no char write occurs.
- At col 5, row 2, send 0x08: one write of 0x20 at 0x044 and cursor col 4. Then at col 0, send 0x08: no write and cursor unchanged.
- Send 0x0C:
  - 512 writes of 0x20 at 0x000..0x1FF.
  - o_ready high again exactly 513 cycles after the accept edge; cursor 0/0.
  - i_char_valid held high during the clear is not consumed.
- Assert i_rst_n=0 at clear write 100 of an FF:
  - o_wr_en goes low immediately and the cursor reads 0/0.
  - After release, 'Q' writes at 0x000.
